// File: rtl/wb_timer.sv
// rtl/wb_timer.sv - Wishbone machine timer (mtime/mtimecmp) and software-interrupt peripheral
// Optional mtime-hi snapshot register enabled by WB_TIMER_SNAPSHOT_EN.
module wb_timer #(
    parameter int unsigned PRESCALE       = 1,
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_wr_en,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_wr_data,
    input  logic [3:0]  wb_wr_sel,
    output logic        wb_ack,
    output logic        wb_stall,
    output logic [31:0] wb_rd_data,
    output logic        timer_interrupt,
    output logic        software_interrupt
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] PS_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] ps_cnt;
    logic          tick;
    logic [63:0]   mtime;
    logic [63:0]   mtime_next;
    logic [63:0]   mtimecmp;
    logic          msip;
    logic          ack_q;
    logic [31:0]   rd_q;
    logic [31:0]   rd_val;
    logic          accept;
    logic          wr_acc;
    logic          rd_acc;
    logic [2:0]    word;
    logic          unused_addr_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return r;
    endfunction

    assign accept           = wb_cyc & wb_stb;
    assign wr_acc           = accept & wb_wr_en;
    assign rd_acc           = accept & ~wb_wr_en;
    assign word             = wb_addr[4:2];
    assign tick             = (ps_cnt == PS_LAST);
    assign unused_addr_bits = ^{wb_addr[31:5], wb_addr[1:0]};

`ifdef WB_TIMER_SNAPSHOT_EN
    logic [31:0] mtime_hi_shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_hi_shadow <= '0;
        end else if (rd_acc && word == 3'd3) begin
            mtime_hi_shadow <= mtime[63:32];
        end else if (wr_acc && word == 3'd4) begin
            mtime_hi_shadow <= merge_bytes(mtime_hi_shadow, wb_wr_data, wb_wr_sel);
        end
    end
`endif

    always_comb begin
        rd_val = '0;
        case (word)
            3'd0: rd_val = {31'b0, msip};
            3'd1: rd_val = mtimecmp[31:0];
            3'd2: rd_val = mtimecmp[63:32];
            3'd3: rd_val = mtime[31:0];
`ifdef WB_TIMER_SNAPSHOT_EN
            3'd4: rd_val = mtime_hi_shadow;
`else
            3'd4: rd_val = mtime[63:32];
`endif
            default: rd_val = '0;
        endcase
    end

    // A bus write to one mtime word overrides the tick for that word and
    // blocks the carry into the other one.
    always_comb begin
        mtime_next = tick ? mtime + 64'd1 : mtime;
        if (wr_acc && (|wb_wr_sel)) begin
            if (word == 3'd3) begin
                mtime_next = {mtime[63:32], merge_bytes(mtime[31:0], wb_wr_data, wb_wr_sel)};
            end else if (word == 3'd4) begin
                mtime_next = {merge_bytes(mtime[63:32], wb_wr_data, wb_wr_sel), mtime[31:0]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_cnt             <= '0;
            mtime              <= '0;
            mtimecmp           <= MTIMECMP_RESET;
            msip               <= 1'b0;
            ack_q              <= 1'b0;
            rd_q               <= '0;
            timer_interrupt    <= 1'b0;
            software_interrupt <= 1'b0;
        end else begin
            ps_cnt             <= tick ? '0 : ps_cnt + 1'b1;
            mtime              <= mtime_next;
            ack_q              <= accept;
            rd_q               <= rd_acc ? rd_val : '0;
            timer_interrupt    <= (mtime >= mtimecmp);
            software_interrupt <= msip;
            if (wr_acc) begin
                case (word)
                    3'd0: if (wb_wr_sel[0]) msip <= wb_wr_data[0];
                    3'd1: mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], wb_wr_data, wb_wr_sel);
                    3'd2: mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wb_wr_data, wb_wr_sel);
                    default: ;
                endcase
            end
        end
    end

    // The master may abandon the cycle; a pending ack is then suppressed.
    assign wb_ack     = ack_q & wb_cyc;
    assign wb_rd_data = wb_ack ? rd_q : '0;
    assign wb_stall   = 1'b0;

endmodule

// File: tb/tb_wb_timer.sv
// tb/tb_wb_timer.sv - self-checking bench for wb_timer (PRESCALE=1 and PRESCALE=4 instances)
module tb_wb_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        wr = 1'b0;
    logic        tgt = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  sel = '0;

    logic        ack1, stall1, tirq1, sirq1;
    logic [31:0] rd1;
    logic        ack4, stall4, tirq4, sirq4;
    logic [31:0] rd4;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    logic        acc_q;
    logic        tgt_q;

    typedef struct {
        logic        w;
        logic [2:0]  word;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t reset_tab[7];
    vec_t reg_tab[13];

    always #5 clk = ~clk;

    wb_timer #(.PRESCALE(1)) u_dut (
        .clk(clk), .rst(rst), .wb_cyc(cyc), .wb_stb(stb & ~tgt), .wb_wr_en(wr),
        .wb_addr(addr), .wb_wr_data(wdata), .wb_wr_sel(sel), .wb_ack(ack1),
        .wb_stall(stall1), .wb_rd_data(rd1), .timer_interrupt(tirq1),
        .software_interrupt(sirq1)
    );

    wb_timer #(.PRESCALE(4)) u_dut4 (
        .clk(clk), .rst(rst), .wb_cyc(cyc), .wb_stb(stb & tgt), .wb_wr_en(wr),
        .wb_addr(addr), .wb_wr_data(wdata), .wb_wr_sel(sel), .wb_ack(ack4),
        .wb_stall(stall4), .wb_rd_data(rd4), .timer_interrupt(tirq4),
        .software_interrupt(sirq4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 1'b0;
            tgt_q <= 1'b0;
        end else begin
            acc_q <= cyc & stb;
            tgt_q <= tgt;
        end
    end

    // Scoreboard: one entry per accepted request, compared against the ack cycle.
    always @(negedge clk) begin
        logic [31:0] e;
        logic        a;
        logic        st;
        logic [31:0] d;
        #1;
        a  = tgt_q ? ack4 : ack1;
        st = tgt_q ? stall4 : stall1;
        d  = tgt_q ? rd4 : rd1;
        if (rst) begin
            exp_q.delete();
        end else begin
            check("stall", st, 0);
            if (acc_q) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack", a, cyc);
                    if (cyc) check("rd_data", d, e);
                    else check("rd_data_dropped", d, 0);
                end
            end else begin
                check("idle_ack", a, 0);
                check("idle_rd_data", d, 0);
            end
        end
    end

    task automatic txn(input logic t, input logic c, input logic s, input logic w,
                       input logic [2:0] word, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] e);
        tgt   = t;
        cyc   = c;
        stb   = s;
        wr    = w;
        addr  = {27'b0, word, 2'b00};
        wdata = d;
        sel   = be;
        if (c && s) exp_q.push_back(w ? 32'h0 : e);
        @(negedge clk);
    endtask

    task automatic rd(input logic [2:0] word, input logic [31:0] e);
        txn(1'b0, 1'b1, 1'b1, 1'b0, word, 32'h0, 4'h0, e);
    endtask

    task automatic wrt(input logic [2:0] word, input logic [31:0] d, input logic [3:0] be);
        txn(1'b0, 1'b1, 1'b1, 1'b1, word, d, be, 32'h0);
    endtask

    task automatic idle();
        txn(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_tab[0] = '{1'b0, 3'd0, 32'h0, 4'h0, 32'h0000_0000};
        reset_tab[1] = '{1'b0, 3'd1, 32'h0, 4'h0, 32'hFFFF_FFFF};
        reset_tab[2] = '{1'b0, 3'd2, 32'h0, 4'h0, 32'hFFFF_FFFF};
        reset_tab[3] = '{1'b0, 3'd3, 32'h0, 4'h0, 32'h0000_0003};
        reset_tab[4] = '{1'b0, 3'd4, 32'h0, 4'h0, 32'h0000_0000};
        reset_tab[5] = '{1'b0, 3'd5, 32'h0, 4'h0, 32'h0000_0000};
        reset_tab[6] = '{1'b0, 3'd7, 32'h0, 4'h0, 32'h0000_0000};

        reg_tab[0]  = '{1'b1, 3'd1, 32'h1122_3344, 4'hF, 32'h0};
        reg_tab[1]  = '{1'b0, 3'd1, 32'h0,         4'h0, 32'h1122_3344};
        reg_tab[2]  = '{1'b1, 3'd1, 32'hAABB_CCDD, 4'h5, 32'h0};
        reg_tab[3]  = '{1'b0, 3'd1, 32'h0,         4'h0, 32'h11BB_33DD};
        reg_tab[4]  = '{1'b1, 3'd2, 32'h0,         4'h8, 32'h0};
        reg_tab[5]  = '{1'b0, 3'd2, 32'h0,         4'h0, 32'h00FF_FFFF};
        reg_tab[6]  = '{1'b1, 3'd5, 32'hDEAD_BEEF, 4'hF, 32'h0};
        reg_tab[7]  = '{1'b0, 3'd5, 32'h0,         4'h0, 32'h0};
        reg_tab[8]  = '{1'b1, 3'd6, 32'h0000_0001, 4'hF, 32'h0};
        reg_tab[9]  = '{1'b0, 3'd6, 32'h0,         4'h0, 32'h0};
        reg_tab[10] = '{1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, 32'h0};
        reg_tab[11] = '{1'b1, 3'd2, 32'hFFFF_FFFF, 4'hF, 32'h0};
        reg_tab[12] = '{1'b0, 3'd2, 32'h0,         4'h0, 32'hFFFF_FFFF};

        repeat (3) @(negedge clk);
        check("reset_ack", ack1, 0);
        check("reset_rd_data", rd1, 0);
        check("reset_tirq", tirq1, 0);
        check("reset_sirq", sirq1, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            txn(1'b0, 1'b1, 1'b1, reset_tab[i].w, reset_tab[i].word,
                reset_tab[i].data, reset_tab[i].be, reset_tab[i].exp);
        for (int i = 0; i < 13; i++)
            txn(1'b0, 1'b1, 1'b1, reg_tab[i].w, reg_tab[i].word,
                reg_tab[i].data, reg_tab[i].be, reg_tab[i].exp);
        idle();
        #2 check("tirq_idle", tirq1, 0);

        // Compare match: mtime passes 5 at the 5th edge after the mtime write.
        wrt(3'd2, 32'h0, 4'hF);
        wrt(3'd3, 32'h0, 4'hF);
        wrt(3'd1, 32'h5, 4'hF);
        for (int m = 2; m <= 8; m++) begin
            idle();
            #2 check($sformatf("tirq_rise_m%0d", m), tirq1, (m >= 6) ? 1 : 0);
        end
        wrt(3'd1, 32'hFFFF_FFFF, 4'hF);
        #2 check("tirq_still_high", tirq1, 1);
        wrt(3'd2, 32'hFFFF_FFFF, 4'hF);
        #2 check("tirq_fall", tirq1, 0);

        wrt(3'd0, 32'h1, 4'h1);
        #2 check("sirq_lag", sirq1, 0);
        idle();
        #2 check("sirq_set", sirq1, 1);
        wrt(3'd0, 32'h0, 4'h0);
        rd(3'd0, 32'h1);
        #2 check("sirq_sel0", sirq1, 1);
        wrt(3'd0, 32'h0, 4'h1);
        idle();
        idle();
        #2 check("sirq_clear", sirq1, 0);

        // Carry from lo into hi.
        wrt(3'd4, 32'h0, 4'hF);
        wrt(3'd3, 32'hFFFF_FFFF, 4'hF);
        idle();
        idle();
        rd(3'd3, 32'h1);
        rd(3'd4, 32'h1);

        // 64-bit wrap, then a partial-byte write to lo on a tick.
        wrt(3'd4, 32'hFFFF_FFFF, 4'hF);
        wrt(3'd3, 32'hFFFF_FFFF, 4'hF);
        idle();
        rd(3'd3, 32'h0);
        rd(3'd4, 32'h0);
        wrt(3'd3, 32'h0000_AB00, 4'h2);
        rd(3'd3, 32'h0000_AB02);
        wrt(3'd4, 32'h5, 4'hF);
        rd(3'd3, 32'h0000_AB03);
        rd(3'd4, 32'h5);

        // lo read at 0x0_FFFFFFFF, hi read after the carry.
        wrt(3'd4, 32'h0, 4'hF);
        wrt(3'd3, 32'hFFFF_FFFF, 4'hF);
        rd(3'd3, 32'hFFFF_FFFF);
`ifdef WB_TIMER_SNAPSHOT_EN
        rd(3'd4, 32'h0);
`else
        rd(3'd4, 32'h1);
`endif

        // Ack dropped by cyc deassertion; the write still lands.
        wrt(3'd1, 32'h1234_5678, 4'hF);
        txn(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 32'h0);
        idle();
        rd(3'd1, 32'h1234_5678);

        // Asynchronous reset while an ack is being presented.
        check("ack_before_reset", ack1, 1);
        rst = 1'b1;
        #2;
        check("reset_kills_ack", ack1, 0);
        check("reset_kills_rd_data", rd1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // PRESCALE=4: mtime advances on every 4th edge after reset release.
        txn(1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 32'h0, 4'hF, 32'h0);
        repeat (39) idle();
        txn(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 32'h0, 4'h0, 32'd10);
        txn(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 32'h0, 4'h0, 32'hFFFF_FFFF);
        txn(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h0, 4'h0, 32'hFFFF_FFFF);
        txn(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 32'h0, 4'h0, 32'd10);
        idle();
        rd(3'd1, 32'hFFFF_FFFF);
        idle();
        idle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_timer.md
Name: wb_timer

Overview:
- Memory-mapped machine timer and software-interrupt peripheral.
- Acts as a pipelined Wishbone responder on a device port of memory_wrapper, so the core can reach it through its data bus.
- Holds a 64-bit free-running mtime counter, a 64-bit mtimecmp register and an msip bit.
- Drives the core's timer_interrupt and software_interrupt inputs.

Parameters:
- PRESCALE, 1: clk cycles per mtime increment; legal values are 1 or greater.
- MTIMECMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- wb_cyc  input  1  Wishbone bus cycle
- wb_stb  input  1  Wishbone strobe
- wb_wr_en  input  1  1 = write, 0 = read
- wb_addr  input  32  byte address; only bits [4:2] are decoded
- wb_wr_data  input  32  write data
- wb_wr_sel  input  4  byte enables; bit n selects byte n
- wb_ack  output  1  response strobe
- wb_stall  output  1  back-pressure; held at 0
- wb_rd_data  output  32  read data, valid while wb_ack is 1
- timer_interrupt  output  1  high when mtime >= mtimecmp
- software_interrupt  output  1  msip bit

Behaviour:
- Register map, word index = wb_addr[4:2]:
  - 0: msip; bit 0 only, other bits read 0.
  - 1: mtimecmp[31:0].
  - 2: mtimecmp[63:32].
  - 3: mtime[31:0].
  - 4: mtime[63:32].
  - 5-7: reserved; reads return 0, writes are ignored, the access is still acked.
- Reset (async): wb_ack=0, wb_rd_data=0, msip=0, mtime=0, mtimecmp=MTIMECMP_RESET, prescale counter=0, timer_interrupt=0, software_interrupt=0.
- Handshake:
  - A request is accepted on a rising edge with wb_cyc & wb_stb. wb_stall=0, so one request can be accepted every cycle.
  - wb_ack rises on the next edge for exactly one cycle per accepted request: latency 1, back-to-back throughput 1/cycle.
  - wb_rd_data is registered together with wb_ack. It is 0 for writes and 0 when wb_ack=0.
  - If wb_cyc is low in the cycle an ack would be presented, that ack is dropped: wb_ack is forced 0 while wb_cyc=0. The write still takes effect.
- Writes: each byte lane is updated only where wb_wr_sel[n]=1. wb_wr_sel=0 updates nothing but is still acked.
- Prescaler:
  - Counter runs 0..PRESCALE-1 and wraps.
  - tick=1 on the cycle the counter equals PRESCALE-1; with PRESCALE=1, tick=1 every cycle.
  - On tick, mtime <= mtime+1. The 64-bit increment wraps modulo 2^64: all-ones becomes 0.
- Simultaneous events:
  - A bus write to mtime lo or hi on a tick cycle: the written bytes take the written value. Unwritten bytes of the addressed word keep their pre-increment value. The other word is unchanged and does not take the carry.
  - A read returns the pre-update value of the register on the acceptance edge.
- timer_interrupt:
  - Registered; equals (mtime >= mtimecmp) using values from the previous cycle, i.e. one cycle after the condition becomes true or false.
  - Level-sensitive: it clears by writing mtimecmp above mtime.
- software_interrupt: registered copy of msip; follows a write to word 0 one cycle after the write edge.
- Reset mid-transfer: any pending ack is discarded and wb_ack=0 immediately, because the reset is asynchronous.

Optional Feature:
- Macro: WB_TIMER_SNAPSHOT_EN.
- Defined:
  - A read of word 3 (mtime lo) also captures mtime[63:32] into a 32-bit shadow register.
  - A read of word 4 returns the shadow instead of live mtime[63:32], giving a consistent 64-bit read as lo followed by hi.
  - The shadow resets to 0.
  - A write to word 4 updates mtime[63:32] and the same bytes of the shadow.
- Not defined: no shadow register; a read of word 4 returns live mtime[63:32].

Test Plan:
- Reset, then read words 0-4 -> 0, 0xFFFFFFFF, 0xFFFFFFFF, 0x0 or small count, 0x0; each wb_ack exactly 1 cycle after acceptance; timer_interrupt=0.
- PRESCALE=4: write mtime lo=0, run 40 clk, read mtime lo -> 10 (±1 tick depending on phase); back-to-back reads of words 1,2,3 -> three consecutive acks with wb_stall=0.
- Write mtimecmp hi=0 then lo=5 with mtime=0 -> timer_interrupt rises 1 cycle after mtime reaches 5. Then write mtimecmp lo=0xFFFFFFFF, hi=0xFFFFFFFF -> timer_interrupt falls.
- Write word 0 data=0x1 with wb_wr_sel=4'b0001 -> software_interrupt=1 next cycle; write with wb_wr_sel=4'b0000 -> msip unchanged, acked.
- Write mtime lo=0xFFFFFFFF, hi=0x00000000, PRESCALE=1, wait 2 ticks -> read hi=1, lo=1 (carry wraps lo into hi). Also write mtime hi=0xFFFFFFFF, lo=0xFFFFFFFF, wait 1 tick -> 64-bit mtime wraps to 0.
- Drop wb_cyc on the cycle after accepting a write -> no wb_ack, but the write is visible on a later read. With WB_TIMER_SNAPSHOT_EN: read lo at mtime=0x0_FFFFFFFF, wait until a carry occurs, read hi -> 0 (shadow), not 1.
